// File: rtl/fifo_sram_ctrl.sv
// fifo_sram_ctrl: circular FIFO sequencer for one single-port synchronous SRAM.
// At most one SRAM access per cycle; a contested push/pop pair is arbitrated
// round-robin, and the write side wins first after reset.
// Optional feature: define FIFO_SRAM_CTRL_ERR_EN to build the sticky
// overflow/underflow flags. Without it, err_ovf/err_unf are tied low.
module fifo_sram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_en,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              err_ovf,
  output logic              err_unf
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_prio_rd;   // 1: read side wins the next contested cycle
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_hold;   // last delivered word, shown when no pop returns

  logic w_push_elig;
  logic w_pop_elig;
  logic w_grant_wr;
  logic w_grant_rd;

  // Flags come straight from the registered occupancy.
  assign full        = (r_count == DEPTH);
  assign empty       = (r_count == {(ADDR_W+1){1'b0}});
  assign count       = r_count;
  assign w_push_elig = wr_en & ~full;
  assign w_pop_elig  = rd_en & ~empty;
  assign wr_ack      = w_grant_wr;
  assign rd_ack      = w_grant_rd;
  assign rd_valid    = r_rd_valid;
  // The SRAM word arrives one cycle after the read access; pass it through in
  // that cycle and otherwise present the last delivered word.
  assign rd_data     = r_rd_valid ? sram_dout : r_rd_hold;

  // Arbitration: grant the single eligible side, or alternate when both are eligible.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (rst) begin
      w_grant_wr = 1'b0;
      w_grant_rd = 1'b0;
    end else if (w_push_elig && w_pop_elig) begin
      w_grant_wr = ~r_prio_rd;
      w_grant_rd = r_prio_rd;
    end else begin
      w_grant_wr = w_push_elig;
      w_grant_rd = w_pop_elig;
    end
  end

  // SRAM command decode for the granted operation; idle keeps the port disabled.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = {ADDR_W{1'b0}};
    sram_din  = {DATA_W{1'b0}};
    if (w_grant_wr) begin
      sram_en   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = r_wr_ptr;
      sram_din  = wr_data;
    end else if (w_grant_rd) begin
      sram_en   = 1'b1;
      sram_we   = 1'b0;
      sram_addr = r_rd_ptr;
    end else begin
      sram_en   = 1'b0;
      sram_we   = 1'b0;
    end
  end

  // Pointers, occupancy and contested-cycle priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= {ADDR_W{1'b0}};
      r_rd_ptr  <= {ADDR_W{1'b0}};
      r_count   <= {(ADDR_W+1){1'b0}};
      r_prio_rd <= 1'b0;
    end else begin
      if (w_grant_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        r_count  <= r_count + (ADDR_W+1)'(1);
      end else if (w_grant_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_count  <= r_count - (ADDR_W+1)'(1);
      end
      if (w_push_elig && w_pop_elig) begin
        r_prio_rd <= w_grant_wr;
      end
    end
  end

  // Read return tracking: valid one cycle after a read grant, then hold the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_hold  <= {DATA_W{1'b0}};
    end else begin
      r_rd_valid <= w_grant_rd;
      if (r_rd_valid) begin
        r_rd_hold <= sram_dout;
      end
    end
  end

`ifdef FIFO_SRAM_CTRL_ERR_EN
  logic r_err_ovf;
  logic r_err_unf;

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (wr_en && full) begin
        r_err_ovf <= 1'b1;
      end
      if (rd_en && empty) begin
        r_err_unf <= 1'b1;
      end
    end
  end

  assign err_ovf = r_err_ovf;
  assign err_unf = r_err_unf;
`else
  assign err_ovf = 1'b0;
  assign err_unf = 1'b0;
`endif

endmodule
